perceptron_trainer_fixed: RTL and testbench



---
 rtl/perceptron_trainer_fixed_pkg.sv | 39 +++
 rtl/perceptron_trainer_fixed_step.sv | 32 +++
 rtl/perceptron_trainer_fixed.sv | 153 +++++++++++++++
 tb/tb_perceptron_trainer_fixed.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_trainer_fixed_pkg.sv
// Shared definitions for the fixed-point perceptron trainer and neuron:
// FSM state codes, default fixed-point constants and the common arithmetic helpers.
package perceptron_trainer_fixed_pkg;

    localparam int FRAC_DEFAULT = 8;
    localparam int ONE_DEFAULT  = 1 << FRAC_DEFAULT;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Operands are sign-extended to 64 bits by the caller, so word widths up to 31 bits are exact.
    function automatic logic signed [63:0] fixed_mul(input logic signed [63:0] a,
                                                     input logic signed [63:0] b,
                                                     input int frac);
        logic signed [63:0] prod;
        prod = a * b;
        return prod >>> frac;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int width);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi)
            return hi;
        else if (sum < lo)
            return lo;
        else
            return sum;
    endfunction

endpackage

// File: rtl/perceptron_trainer_fixed_step.sv
// Combinational perceptron decision: net = w0*ONE + w1*x1 + w2*x2 in tam+2 bits, y = (net >= 0).
module perceptron_step_fixed
    import perceptron_trainer_fixed_pkg::*;
#(
    parameter int tam  = 16,
    parameter int frac = 8
) (
    input  logic [tam-1:0] w0,
    input  logic [tam-1:0] w1,
    input  logic [tam-1:0] w2,
    input  logic [tam-1:0] x1,
    input  logic [tam-1:0] x2,
    output logic           y
);

    localparam logic signed [63:0] ONE_W = 64'sd1 <<< frac;

    logic [tam+1:0] p0;
    logic [tam+1:0] p1;
    logic [tam+1:0] p2;
    logic [tam+1:0] net;

    // Each shifted product is truncated to tam+2 bits and the sum wraps, matching the neuron.
    always_comb begin
        p0  = (tam+2)'(fixed_mul(64'($signed(w0)), ONE_W, frac));
        p1  = (tam+2)'(fixed_mul(64'($signed(w1)), 64'($signed(x1)), frac));
        p2  = (tam+2)'(fixed_mul(64'($signed(w2)), 64'($signed(x2)), frac));
        net = p0 + p1 + p2;
        y   = ~net[tam+1];
    end

endmodule

// File: rtl/perceptron_trainer_fixed.sv
// Sequential fixed-point perceptron trainer: sweeps a 4-sample truth table, two cycles per sample,
// until an error-free epoch or the epoch limit, and presents the learned weights for a neuron.
module perceptron_trainer_fixed
    import perceptron_trainer_fixed_pkg::*;
#(
    parameter int tam       = 16,
    parameter int frac      = 8,
    parameter int lr_shift  = 1,
    parameter int max_epoch = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0][tam-1:0] in1,
    input  logic [3:0][tam-1:0] in2,
    input  logic [3:0][tam-1:0] d,
    input  logic [tam-1:0]      init_w0,
    input  logic [tam-1:0]      init_w1,
    input  logic [tam-1:0]      init_w2,
    output logic [tam-1:0]      w0,
    output logic [tam-1:0]      w1,
    output logic [tam-1:0]      w2,
    output logic                busy,
    output logic                done,
    output logic                converged,
    output logic [7:0]          epoch_count
);

    localparam logic signed [63:0] ONE_W = 64'sd1 <<< frac;

    logic [1:0]           state;
    logic [1:0]           k;
    logic                 err_flag;
    logic                 y_r;
    logic [3:0][tam-1:0]  x1_r;
    logic [3:0][tam-1:0]  x2_r;
    logic [3:0]           cls_r;

    logic                 y;
    logic                 e_pos;
    logic                 e_neg;
    logic                 sample_err;
    logic signed [63:0]   delta0;
    logic signed [63:0]   delta1;
    logic signed [63:0]   delta2;
    logic [tam-1:0]       nw0;
    logic [tam-1:0]       nw1;
    logic [tam-1:0]       nw2;
    logic [7:0]           next_epoch;

    perceptron_step_fixed #(
        .tam  (tam),
        .frac (frac)
    ) u_step (
        .w0 (w0),
        .w1 (w1),
        .w2 (w2),
        .x1 (x1_r[k]),
        .x2 (x2_r[k]),
        .y  (y)
    );

    // Error is +1 (target 1, predicted 0) or -1 (target 0, predicted 1); the bias input is ONE.
    always_comb begin
        e_pos      = cls_r[k] & ~y_r;
        e_neg      = ~cls_r[k] & y_r;
        sample_err = e_pos | e_neg;
        delta0     = ONE_W >>> lr_shift;
        delta1     = 64'($signed(x1_r[k])) >>> lr_shift;
        delta2     = 64'($signed(x2_r[k])) >>> lr_shift;
        nw0        = tam'(sat_add(64'($signed(w0)), e_neg ? -delta0 : delta0, tam));
        nw1        = tam'(sat_add(64'($signed(w1)), e_neg ? -delta1 : delta1, tam));
        nw2        = tam'(sat_add(64'($signed(w2)), e_neg ? -delta2 : delta2, tam));
        next_epoch = epoch_count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            k           <= 2'd0;
            err_flag    <= 1'b0;
            y_r         <= 1'b0;
            x1_r        <= '0;
            x2_r        <= '0;
            cls_r       <= '0;
            w0          <= '0;
            w1          <= '0;
            w2          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            epoch_count <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x1_r        <= in1;
                        x2_r        <= in2;
                        for (int i = 0; i < 4; i++)
                            cls_r[i] <= |d[i];
                        w0          <= init_w0;
                        w1          <= init_w1;
                        w2          <= init_w2;
                        epoch_count <= 8'd0;
                        k           <= 2'd0;
                        converged   <= 1'b0;
                        err_flag    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_CALC;
                    end
                end
                S_CALC: begin
                    y_r   <= y;
                    state <= S_UPD;
                end
                S_UPD: begin
                    if (sample_err) begin
                        err_flag <= 1'b1;
                        w0       <= nw0;
                        w1       <= nw1;
                        w2       <= nw2;
                    end
                    if (k != 2'd3) begin
                        k     <= k + 2'd1;
                        state <= S_CALC;
                    end else begin
                        // The current sample's error counts towards this epoch's flag.
                        epoch_count <= next_epoch;
                        if (!(err_flag || sample_err)) begin
                            converged <= 1'b1;
                            state     <= S_DONE;
                        end else if (next_epoch == 8'(max_epoch)) begin
                            converged <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            err_flag <= 1'b0;
                            k        <= 2'd0;
                            state    <= S_CALC;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer_fixed.sv
// Self-checking bench: three trainer instances (default, max_epoch=8, lr_shift=0) driven by directed
// steps, with expected training results queued at start and compared when done pulses.
module tb_perceptron_trainer_fixed;

    localparam int ONE = 256;

    typedef struct {
        string       tag;
        int          lat;
        logic        conv;
        logic [7:0]  ep;
        logic        chk_w;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_v [3];
    logic [3:0][15:0]  in1;
    logic [3:0][15:0]  in2;
    logic [3:0][15:0]  d;
    logic [15:0]       iw0;
    logic [15:0]       iw1;
    logic [15:0]       iw2;
    logic [15:0]       w0_o [3];
    logic [15:0]       w1_o [3];
    logic [15:0]       w2_o [3];
    logic              busy_o [3];
    logic              done_o [3];
    logic              conv_o [3];
    logic [7:0]        ep_o [3];

    int   cycle    = 0;
    int   pulses_a = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    perceptron_trainer_fixed u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .in1(in1), .in2(in2), .d(d),
        .init_w0(iw0), .init_w1(iw1), .init_w2(iw2),
        .w0(w0_o[0]), .w1(w1_o[0]), .w2(w2_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .converged(conv_o[0]), .epoch_count(ep_o[0])
    );

    perceptron_trainer_fixed #(.max_epoch(8)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .in1(in1), .in2(in2), .d(d),
        .init_w0(iw0), .init_w1(iw1), .init_w2(iw2),
        .w0(w0_o[1]), .w1(w1_o[1]), .w2(w2_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .converged(conv_o[1]), .epoch_count(ep_o[1])
    );

    perceptron_trainer_fixed #(.lr_shift(0)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .in1(in1), .in2(in2), .d(d),
        .init_w0(iw0), .init_w1(iw1), .init_w2(iw2),
        .w0(w0_o[2]), .w1(w1_o[2]), .w2(w2_o[2]), .busy(busy_o[2]), .done(done_o[2]),
        .converged(conv_o[2]), .epoch_count(ep_o[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) if (done_o[0] === 1'b1) pulses_a <= pulses_a + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input int which, output int t0);
        @(negedge clk);
        start_v[which] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cycle;
        start_v[which] = 1'b0;
    endtask

    task automatic setOrInputs();
        in1[0] = 16'(0);   in1[1] = 16'(ONE); in1[2] = 16'(0);   in1[3] = 16'(ONE);
        in2[0] = 16'(0);   in2[1] = 16'(0);   in2[2] = 16'(ONE); in2[3] = 16'(ONE);
        d[0]   = 16'(0);   d[1]   = 16'(ONE); d[2]   = 16'(ONE); d[3]   = 16'(ONE);
        iw0 = 16'h0000; iw1 = 16'h0000; iw2 = 16'h0000;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_w0"}, 32'(w0_o[0]), 32'h0);
        checkOutput({tag, "_w1"}, 32'(w1_o[0]), 32'h0);
        checkOutput({tag, "_w2"}, 32'(w2_o[0]), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy_o[0]), 32'h0);
        checkOutput({tag, "_done"}, 32'(done_o[0]), 32'h0);
        checkOutput({tag, "_conv"}, 32'(conv_o[0]), 32'h0);
        checkOutput({tag, "_epoch"}, 32'(ep_o[0]), 32'h0);
    endtask

    // Bounded wait for done; an expired budget shows up as a failed done_seen comparison.
    task automatic scoreRun(input int which, input int t0);
        exp_t e;
        logic ok;
        int   t1;
        ok = 1'b0;
        t1 = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (done_o[which] === 1'b1) begin
                ok = 1'b1;
                t1 = cycle;
            end
        end
        e = sb.pop_front();
        checkOutput({e.tag, "_done_seen"}, 32'(ok), 32'h1);
        checkOutput({e.tag, "_latency"}, 32'(t1 - t0), 32'(e.lat));
        checkOutput({e.tag, "_converged"}, 32'(conv_o[which]), 32'(e.conv));
        checkOutput({e.tag, "_epochs"}, 32'(ep_o[which]), 32'(e.ep));
        checkOutput({e.tag, "_busy_at_done"}, 32'(busy_o[which]), 32'h0);
        if (e.chk_w) begin
            checkOutput({e.tag, "_w0"}, 32'(w0_o[which]), 32'(e.w0));
            checkOutput({e.tag, "_w1"}, 32'(w1_o[which]), 32'(e.w1));
            checkOutput({e.tag, "_w2"}, 32'(w2_o[which]), 32'(e.w2));
        end
        @(posedge clk);
        #1;
        checkOutput({e.tag, "_done_one_cycle"}, 32'(done_o[which]), 32'h0);
        checkOutput({e.tag, "_busy_after"}, 32'(busy_o[which]), 32'h0);
    endtask

    initial begin
        int t0;
        int snap;
        exp_t or_exp;
        or_exp = '{tag: "or", lat: 33, conv: 1'b1, ep: 8'd4, chk_w: 1'b1,
                   w0: 16'hFF80, w1: 16'h0080, w2: 16'h0080};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        setOrInputs();
        repeat (2) @(posedge clk);
        #1;
        checkIdleZero("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] OR training");
        sb.push_back(or_exp);
        applyStimulus(0, t0);
        scoreRun(0, t0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("or_hold_w0", 32'(w0_o[0]), 32'h0000FF80);
        checkOutput("or_hold_w1", 32'(w1_o[0]), 32'h00000080);

        $display("[TB] XOR non-convergence");
        d[3] = 16'(0);
        sb.push_back('{tag: "xor", lat: 65, conv: 1'b0, ep: 8'd8, chk_w: 1'b0,
                       w0: 16'h0, w1: 16'h0, w2: 16'h0});
        applyStimulus(1, t0);
        scoreRun(1, t0);

        $display("[TB] Saturation");
        for (int i = 0; i < 4; i++) begin
            in1[i] = 16'(ONE);
            in2[i] = 16'(0);
            d[i]   = 16'(ONE);
        end
        iw0 = 16'h8000; iw1 = 16'h7FC0; iw2 = 16'h0000;
        applyStimulus(2, t0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sat_w1", 32'(w1_o[2]), 32'h00007FFF);
        checkOutput("sat_w0", 32'(w0_o[2]), 32'h00008100);
        checkOutput("sat_w2", 32'(w2_o[2]), 32'h00000000);

        $display("[TB] Start while busy with input change");
        setOrInputs();
        or_exp.tag = "or_busy";
        sb.push_back(or_exp);
        snap = pulses_a;
        applyStimulus(0, t0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b1;
        d[0] = 16'(ONE); d[1] = 16'(0); d[2] = 16'(0); d[3] = 16'(0);
        in1[3] = 16'(0);
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        scoreRun(0, t0);
        checkOutput("or_busy_pulse_count", 32'(pulses_a - snap), 32'h1);
        setOrInputs();

        $display("[TB] Reset mid-operation");
        applyStimulus(0, t0);
        repeat (10) @(posedge clk);
        snap = pulses_a;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkIdleZero("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midreset_no_done", 32'(pulses_a - snap), 32'h0);
        checkOutput("midreset_idle", 32'(busy_o[0]), 32'h0);

        or_exp.tag = "or_after_reset";
        sb.push_back(or_exp);
        applyStimulus(0, t0);
        scoreRun(0, t0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
